result_unloader: RTL

Reader side of the result memory in the matrix-multiply datapath. After a start pulse it walks N_WORDS 18-bit result entries. For each entry it drives the result-memory address, read enable and 2-bit part select, and captures the 8-bit Dataout slice for each part. It sends the slices as a byte stream over a valid/ready handshake to the host/testbench side, 3 bytes per result word.

---
 rtl/result_unloader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// Streams N_WORDS 18-bit result-memory entries as 3 bytes each (LSB slice first) over valid/ready.
// Optional trailing XOR checksum byte when UNLOAD_CHECKSUM_EN is defined.
module result_unloader #(
  parameter int N_WORDS   = 9,
  parameter int ADDR_BASE = 0,
  parameter int ADDR_W    = 5,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              memout_read,
  output logic [ADDR_W-1:0] memout_addr,
  output logic [1:0]        part,
  input  logic [7:0]        Dataout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(ADDR_BASE);

`ifdef UNLOAD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LOAD, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LOAD, S_SEND, S_DONE} state_t;
`endif

  state_t r_state, w_nxt_state;

  logic              r_read,     w_nxt_read;
  logic [ADDR_W-1:0] r_addr,     w_nxt_addr;
  logic [1:0]        r_part,     w_nxt_part;
  logic [7:0]        r_tx_data,  w_nxt_tx_data;
  logic              r_tx_valid, w_nxt_tx_valid;
  logic              r_busy,     w_nxt_busy;
  logic              r_done,     w_nxt_done;
  logic [WORD_W-1:0] r_word,     w_nxt_word;
  logic [LAT_W-1:0]  r_lat_cnt,  w_nxt_lat_cnt;
`ifdef UNLOAD_CHECKSUM_EN
  logic [7:0]        r_csum,     w_nxt_csum;
`endif

  logic w_hs;
  logic w_last_part;
  logic w_last_word;
  logic w_lat_done;

  assign w_hs        = r_tx_valid & tx_ready;
  assign w_last_part = (r_part == 2'd2);
  assign w_last_word = (r_word == LAST_WORD);
  assign w_lat_done  = (r_lat_cnt == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_nxt_state = S_RD;
      S_RD:   if (w_lat_done) w_nxt_state = S_LOAD;
      S_LOAD: w_nxt_state = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          if (!w_last_part)      w_nxt_state = S_LOAD;
          else if (!w_last_word) w_nxt_state = S_RD;
`ifdef UNLOAD_CHECKSUM_EN
          else                   w_nxt_state = S_CSUM;
`else
          else                   w_nxt_state = S_DONE;
`endif
        end
      end
`ifdef UNLOAD_CHECKSUM_EN
      S_CSUM: if (w_hs) w_nxt_state = S_DONE;
`endif
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; done defaults low so it is a single-cycle pulse.
  always_comb begin
    w_nxt_read     = r_read;
    w_nxt_addr     = r_addr;
    w_nxt_part     = r_part;
    w_nxt_tx_data  = r_tx_data;
    w_nxt_tx_valid = r_tx_valid;
    w_nxt_busy     = r_busy;
    w_nxt_done     = 1'b0;
    w_nxt_word     = r_word;
    w_nxt_lat_cnt  = r_lat_cnt;
`ifdef UNLOAD_CHECKSUM_EN
    w_nxt_csum     = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_read    = 1'b1;
          w_nxt_addr    = BASE_ADDR;
          w_nxt_part    = 2'd0;
          w_nxt_busy    = 1'b1;
          w_nxt_word    = '0;
          w_nxt_lat_cnt = '0;
`ifdef UNLOAD_CHECKSUM_EN
          w_nxt_csum    = 8'd0;
`endif
        end
      end
      S_RD: begin
        if (!w_lat_done) w_nxt_lat_cnt = r_lat_cnt + 1'b1;
      end
      S_LOAD: begin
        w_nxt_tx_data  = Dataout;
        w_nxt_tx_valid = 1'b1;
      end
      S_SEND: begin
        if (w_hs) begin
          w_nxt_tx_valid = 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
          w_nxt_csum     = r_csum ^ r_tx_data;
`endif
          if (!w_last_part) begin
            w_nxt_part = r_part + 2'd1;
          end else if (!w_last_word) begin
            w_nxt_word    = r_word + 1'b1;
            w_nxt_addr    = r_addr + 1'b1;
            w_nxt_part    = 2'd0;
            w_nxt_lat_cnt = '0;
          end else begin
`ifdef UNLOAD_CHECKSUM_EN
            // Fold the final data byte in directly so the checksum is presented next cycle.
            w_nxt_tx_data  = r_csum ^ r_tx_data;
            w_nxt_tx_valid = 1'b1;
`else
            w_nxt_done     = 1'b1;
`endif
          end
        end
      end
`ifdef UNLOAD_CHECKSUM_EN
      S_CSUM: begin
        if (w_hs) begin
          w_nxt_tx_valid = 1'b0;
          w_nxt_done     = 1'b1;
        end
      end
`endif
      S_DONE: begin
        w_nxt_read = 1'b0;
        w_nxt_busy = 1'b0;
      end
      default: begin
        w_nxt_read     = 1'b0;
        w_nxt_tx_valid = 1'b0;
        w_nxt_busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read     <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_part     <= 2'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_word     <= '0;
      r_lat_cnt  <= '0;
`ifdef UNLOAD_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_read     <= w_nxt_read;
      r_addr     <= w_nxt_addr;
      r_part     <= w_nxt_part;
      r_tx_data  <= w_nxt_tx_data;
      r_tx_valid <= w_nxt_tx_valid;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_word     <= w_nxt_word;
      r_lat_cnt  <= w_nxt_lat_cnt;
`ifdef UNLOAD_CHECKSUM_EN
      r_csum     <= w_nxt_csum;
`endif
    end
  end

  assign memout_read = r_read;
  assign memout_addr = r_addr;
  assign part        = r_part;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
